// File: rtl/uart_pkg.sv
// Shared UART arbitration types and helpers.
//   arb_state_t   : arbiter FSM encoding (idle / packet-locked grant)
//   next_rr_index : cyclic first-set search starting at a pointer
package uart_pkg;

    // Widest requester vector the round-robin helper supports.
    localparam int unsigned RrMaxReq = 16;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Returns the first index with valid_vec set, searching ptr, ptr+1, ... modulo n.
    // Returns 0 when nothing is set; callers qualify with their own found flag.
    function automatic logic [3:0] next_rr_index(input logic [RrMaxReq-1:0] valid_vec,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
        logic [3:0]  idx;
        logic        found;
        int unsigned cand;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RrMaxReq; k++) begin
            cand = ptr + k;
            // Explicit wrap instead of modulo: n need not be a power of two.
            if (cand >= n) begin
                cand = cand - n;
            end
            if (!found && (k < n) && valid_vec[cand[3:0]]) begin
                idx   = cand[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector.
//   valid_i : request vector
//   ptr_i   : index with highest priority this round
//   idx_o   : first requesting index at or after ptr_i (cyclic)
//   found_o : at least one request is present
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              found_o
);

    logic [RrMaxReq-1:0] valid_ext;
    logic [3:0]          idx;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NumReq-1:0]    = valid_i;
        idx                      = next_rr_index(valid_ext, 32'(ptr_i), NumReq);
        idx_o                    = IdxW'(idx);
        found_o                  = |valid_i;
    end

endmodule

// File: rtl/uart_tx_arbiter_axis.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between several AXIS sources.
//   din_axis_*  : NUM_REQUESTERS byte sources, requester i at tdata[i*WORD_WIDTH +: WORD_WIDTH]
//   dout_axis_* : one-entry registered stream towards the transmitter
//   grant_id    : current or most recent grantee
//   busy        : grant held or output register occupied
// Build option: define UART_TX_ARB_PRIO0_EN to give requester 0 strict priority when idle.
module uart_tx_arbiter_axis
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned GAP_LIMIT      = 1024,
    localparam int unsigned GrantW = $clog2(NUM_REQUESTERS > 1 ? NUM_REQUESTERS : 2)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] din_axis_tdata,
    input  logic [NUM_REQUESTERS-1:0]        din_axis_tvalid,
    input  logic [NUM_REQUESTERS-1:0]        din_axis_tlast,
    output logic [NUM_REQUESTERS-1:0]        din_axis_tready,
    output logic [WORD_WIDTH-1:0]            dout_axis_tdata,
    output logic                             dout_axis_tvalid,
    input  logic                             dout_axis_tready,
    output logic [GrantW-1:0]                grant_id,
    output logic                             busy
);

    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
    localparam int unsigned GapW  = $clog2(GAP_LIMIT + 1);

    arb_state_t             state_q, state_d;
    logic [GrantW-1:0]      grant_q, grant_d;
    logic [GrantW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                   dout_valid_q, dout_valid_d;
    logic [WORD_WIDTH-1:0]  dout_data_q, dout_data_d;

    logic [GrantW-1:0]      pick_idx, sel_idx, ptr_after;
    logic                   pick_found;
    logic                   g_valid, g_last, out_space, take;
    logic [WORD_WIDTH-1:0]  g_data;

    uart_rr_picker #(
        .NumReq (NUM_REQUESTERS),
        .IdxW   (GrantW)
    ) u_picker (
        .valid_i (din_axis_tvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

`ifdef UART_TX_ARB_PRIO0_EN
    assign sel_idx = din_axis_tvalid[0] ? '0 : pick_idx;
`else
    assign sel_idx = pick_idx;
`endif

    assign g_valid   = din_axis_tvalid[grant_q];
    assign g_last    = din_axis_tlast[grant_q];
    assign g_data    = din_axis_tdata[grant_q*WORD_WIDTH +: WORD_WIDTH];
    // Output register can accept when empty or draining this cycle.
    assign out_space = dout_axis_tready || !dout_valid_q;
    assign take      = (state_q == ARB_GRANT) && g_valid && out_space;
    assign ptr_after = (grant_q == GrantW'(NUM_REQUESTERS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        din_axis_tready = '0;
        if (state_q == ARB_GRANT) begin
            din_axis_tready[grant_q] = out_space;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        dout_valid_d = dout_valid_q && !dout_axis_tready;
        dout_data_d  = dout_data_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d    = sel_idx;
                    state_d    = ARB_GRANT;
                    beat_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (take) begin
                    dout_valid_d = 1'b1;
                    dout_data_d  = g_data;
                    gap_cnt_d    = '0;
                    if (g_last || (beat_cnt_q == BeatW'(MAX_BURST - 1))) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = ptr_after;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (!g_valid) begin
                    if (gap_cnt_q == GapW'(GAP_LIMIT - 1)) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = ptr_after;
                        beat_cnt_d = '0;
                        gap_cnt_d  = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
        end
    end

    assign dout_axis_tdata  = dout_data_q;
    assign dout_axis_tvalid = dout_valid_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q == ARB_GRANT) || dout_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter_axis.sv
// Directed bench for uart_tx_arbiter_axis (4 requesters, MAX_BURST=16, GAP_LIMIT=8).
module tb_uart_tx_arbiter_axis;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;
    localparam int GL = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] tdata;
    logic [N-1:0]   tvalid, tlast, tready;
    logic [W-1:0]   dout_data;
    logic           dout_valid, dout_ready;
    logic [1:0]     grant_id;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter_axis #(
        .NUM_REQUESTERS (N),
        .WORD_WIDTH     (W),
        .MAX_BURST      (MB),
        .GAP_LIMIT      (GL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .din_axis_tdata   (tdata),
        .din_axis_tvalid  (tvalid),
        .din_axis_tlast   (tlast),
        .din_axis_tready  (tready),
        .dout_axis_tdata  (dout_data),
        .dout_axis_tvalid (dout_valid),
        .dout_axis_tready (dout_ready),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    // Per-requester source scripts: {last, data}.
    logic [8:0] src_mem [N][32];
    int         src_len [N];
    int         src_pos [N];
    logic [N-1:0] hs;
    logic       out_hs;
    logic [7:0] out_word;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) begin
                tvalid[i]       = 1'b1;
                tdata[i*W +: W] = src_mem[i][src_pos[i]][7:0];
                tlast[i]        = src_mem[i][src_pos[i]][8];
            end else begin
                tvalid[i]       = 1'b0;
                tdata[i*W +: W] = '0;
                tlast[i]        = 1'b0;
            end
        end
    endtask

    task automatic capture();
        hs       = tvalid & tready;
        out_hs   = dout_valid & dout_ready;
        out_word = dout_data;
    endtask

    task automatic settle();
        #1;
        capture();
    endtask

    // One clock: commit handshakes seen at the previous negedge, then sample at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (out_hs) got.push_back(out_word);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_pos[i]++;
        refresh();
        @(negedge clk);
        capture();
    endtask

    // mode: 0 no tlast, 1 tlast on final word, 2 tlast on every word
    task automatic load(input int i, input logic [7:0] d0, input logic [7:0] inc,
                        input int len, input int mode);
        for (int k = 0; k < len; k++) begin
            src_mem[i][k][7:0] = d0 + inc * 8'(k);
            src_mem[i][k][8]   = (mode == 2) || ((mode == 1) && (k == len - 1));
        end
        src_len[i] = len;
        src_pos[i] = 0;
        refresh();
        settle();
    endtask

    task automatic wait_got(input string tag, input int n, input int bound);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < bound) begin
            tick();
            cyc++;
        end
        chk(tag, got.size(), n);
    endtask

    task automatic chk_got(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got.size()) chk($sformatf("%s_w%0d", tag, k), got[k], exp_q[k]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        refresh();
        @(negedge clk);
        capture();
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_tready", tready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single packet from requester 2.
        load(2, 8'hA5, 8'h97, 2, 1);   // A5, 3C
        chk("sp_idle_tready", tready, 0);
        tick();
        chk("sp_grant_id", grant_id, 2);
        chk("sp_tready", tready, 4'b0100);
        chk("sp_busy", busy, 1);
        tick();
        chk("sp_dout0_valid", dout_valid, 1);
        chk("sp_dout0_data", dout_data, 8'hA5);
        tick();
        chk("sp_dout1_data", dout_data, 8'h3C);
        chk("sp_release_tready", tready, 0);
        tick();
        chk("sp_drained_valid", dout_valid, 0);
        chk("sp_drained_busy", busy, 0);
        exp_q = '{8'hA5, 8'h3C};
        chk_got("sp");

        // Round robin: rr_ptr is 3 after requester 2; one word per two cycles.
        for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i), 8'h00, 2, 2);
        for (int c = 0; c < 16; c++) tick();
        chk("rr_count_t16", got.size(), 7);
        tick();
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h10 + 8'((3 + k) % 4));
        chk_got("rr");
        tick();
        tick();

        // Burst limit: requester 1 rotated out after 16 beats, requester 3 served, then 1 resumes.
        load(1, 8'h00, 8'h01, 20, 1);
        tick();
        chk("bl_grant_id", grant_id, 1);
        load(3, 8'hC0, 8'h01, 2, 1);
        wait_got("bl_timeout", 22, 200);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        for (int k = 16; k < 20; k++) exp_q.push_back(8'(k));
        chk_got("bl");
        tick();
        tick();

        // Backpressure mid-packet: output and tready frozen, nothing lost or duplicated.
        load(0, 8'h60, 8'h01, 6, 1);
        wait_got("bp_pre_timeout", 2, 50);
        dout_ready = 1'b0;
        settle();
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("bp_hold_data", dout_data, 8'h62);
            chk("bp_hold_valid", dout_valid, 1);
            chk("bp_hold_tready", tready, 0);
        end
        dout_ready = 1'b1;
        settle();
        wait_got("bp_timeout", 6, 50);
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h60 + 8'(k));
        chk_got("bp");
        tick();
        tick();

        // Gap timeout: requester 0 goes quiet without tlast; released after 8 idle cycles.
        load(0, 8'h55, 8'h00, 1, 0);
        tick();
        chk("gap_grant0", grant_id, 0);
        load(1, 8'h77, 8'h00, 1, 1);
        tick();
        for (int c = 0; c < 7; c++) tick();
        chk("gap_still_granted", tready, 4'b0001);
        tick();
        chk("gap_released_tready", tready, 0);
        chk("gap_released_grant", grant_id, 0);
        tick();
        chk("gap_next_grant", grant_id, 1);
        chk("gap_next_tready", tready, 4'b0010);
        wait_got("gap_timeout", 2, 20);
        exp_q = '{8'h55, 8'h77};
        chk_got("gap");
        tick();

        // Reset mid-packet.
        load(2, 8'hE0, 8'h01, 3, 1);
        tick();
        tick();
        chk("mr_pre_valid", dout_valid, 1);
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("mr_dout_valid", dout_valid, 0);
        chk("mr_dout_data", dout_data, 0);
        chk("mr_tready", tready, 0);
        chk("mr_grant_id", grant_id, 0);
        chk("mr_busy", busy, 0);
        for (int i = 0; i < N; i++) src_len[i] = 0;
        refresh();
        settle();
        tick();
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        settle();
        tick();
        chk("mr_idle_tready", tready, 0);
        chk("mr_idle_grant", grant_id, 0);
        chk("mr_idle_busy", busy, 0);
        // rr_ptr back at 0: requester 1 wins over 3.
        load(1, 8'h21, 8'h00, 1, 1);
        load(3, 8'h23, 8'h00, 1, 1);
        tick();
        chk("mr_ptr_reset_grant", grant_id, 1);
        got.delete();
        wait_got("mr_timeout", 2, 20);
        exp_q = '{8'h21, 8'h23};
        chk_got("mr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
